array_rval_scan_reader: RTL and testbench

Read-side counterpart to the array element write/force path. Holds an array of WIDTH-bit entries indexed LO..HI (non-zero-based allowed), with a force/release overlay per entry. Provides a registered random-read port that flags out-of-range and undefined (X/Z) indices, plus a sequential scan engine that streams every entry high-to-low. Used as the checker-side model in array select regression benches.

---
 rtl/array_rval_scan_reader.sv | 205 ++++++++++++++++++++
 tb/tb_array_rval_scan_reader.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_rval_scan_reader.sv
// Indexed array with force/release overlay, registered random read,
// and a high-to-low scan engine streaming effective entry values.
module array_rval_scan_reader #(
   parameter int               WIDTH   = 2,
   parameter int               LO      = 1,
   parameter int               HI      = 2,
   parameter int               IDX_W   = 4,
   parameter logic [WIDTH-1:0] DEFAULT = '0
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_wr_en,
   input  logic [IDX_W-1:0] i_wr_idx,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_frc_en,
   input  logic             i_frc_rel,
   input  logic [IDX_W-1:0] i_frc_idx,
   input  logic [WIDTH-1:0] i_frc_data,
   input  logic             i_rd_req,
   input  logic [IDX_W-1:0] i_rd_idx,
   output logic             o_rd_ack,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_rd_oob,
   output logic             o_rd_undef,
   input  logic             i_scan_start,
   output logic             o_scan_busy,
   output logic             o_scan_valid,
   output logic [IDX_W-1:0] o_scan_idx,
   output logic [WIDTH-1:0] o_scan_data,
   output logic             o_scan_done,
   output logic [7:0]       o_err_count
);

   localparam int               N    = HI - LO + 1;
   localparam logic [IDX_W-1:0] LO_I = IDX_W'(LO);
   localparam logic [IDX_W-1:0] HI_I = IDX_W'(HI);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_DONE
   } state_t;

   logic [WIDTH-1:0] r_base [N];
   logic [WIDTH-1:0] r_fval [N];
   logic [N-1:0]     r_flag;
   logic [WIDTH-1:0] w_eff  [N];

   logic [7:0]       r_err;
   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W-1:0] w_ptr_nxt;

   logic             w_wr_ok;
   logic             w_frc_ok;
   logic             w_frc_bad;
   logic             w_rd_ok;
   logic             w_rd_undef;
   logic             w_err_ev;
   logic [IDX_W-1:0] w_wr_off;
   logic [IDX_W-1:0] w_frc_off;
   logic [IDX_W-1:0] w_rd_off;
   logic [IDX_W-1:0] w_scan_off;
   logic [WIDTH-1:0] w_rd_val;
   logic [WIDTH-1:0] w_scan_val;

   // X/Z bits make an index undefined; such an index is never legal
   function automatic logic f_legal(input logic [IDX_W-1:0] idx);
      if ($isunknown(idx)) return 1'b0;
      return (idx >= LO_I) && (idx <= HI_I);
   endfunction

   assign w_rd_undef = $isunknown(i_rd_idx);
   assign w_wr_ok    = i_wr_en && f_legal(i_wr_idx);
   assign w_frc_ok   = (i_frc_en || i_frc_rel) && f_legal(i_frc_idx);
   assign w_frc_bad  = (i_frc_en || i_frc_rel) && !f_legal(i_frc_idx);
   assign w_rd_ok    = f_legal(i_rd_idx);
   assign w_err_ev   = (i_wr_en && !w_wr_ok) || w_frc_bad ||
                       (i_rd_req && !w_rd_ok);

   assign w_wr_off   = i_wr_idx - LO_I;
   assign w_frc_off  = i_frc_idx - LO_I;
   assign w_rd_off   = i_rd_idx - LO_I;
   assign w_scan_off = r_ptr - LO_I;

   // Effective value: forced value overlays the base value
   always_comb begin
      for (int i = 0; i < N; i++) begin
         w_eff[i] = r_flag[i] ? r_fval[i] : r_base[i];
      end
   end

   // Select effective values for the read port and the scan pointer
   always_comb begin
      w_rd_val   = DEFAULT;
      w_scan_val = DEFAULT;
      for (int i = 0; i < N; i++) begin
         if (w_rd_off == IDX_W'(i)) w_rd_val = w_eff[i];
         if (w_scan_off == IDX_W'(i)) w_scan_val = w_eff[i];
      end
   end

   // Base storage and force overlay; force strobe beats release
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < N; i++) begin
            r_base[i] <= DEFAULT;
            r_fval[i] <= DEFAULT;
            r_flag[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (w_wr_ok && w_wr_off == IDX_W'(i)) begin
               r_base[i] <= i_wr_data;
            end
            if (w_frc_ok && w_frc_off == IDX_W'(i)) begin
               if (i_frc_en) begin
                  r_flag[i] <= 1'b1;
                  r_fval[i] <= i_frc_data;
               end else begin
                  r_flag[i] <= 1'b0;
               end
            end
         end
      end
   end

   // Registered read response, sampled before this edge's updates
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_rd_ack   <= 1'b0;
         o_rd_data  <= '0;
         o_rd_oob   <= 1'b0;
         o_rd_undef <= 1'b0;
      end else begin
         o_rd_ack <= i_rd_req;
         if (i_rd_req) begin
            o_rd_data  <= w_rd_ok ? w_rd_val : DEFAULT;
            o_rd_undef <= w_rd_undef;
            o_rd_oob   <= !w_rd_undef && !w_rd_ok;
         end
      end
   end

   // Illegal-access counter: one step per cycle, saturating
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_err <= '0;
      end else if (w_err_ev && r_err != 8'hFF) begin
         r_err <= r_err + 8'd1;
      end
   end

   assign o_err_count = r_err;

   // Scan state and pointer registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   // Scan next-state and outputs; start is ignored outside IDLE
   always_comb begin
      w_state_nxt  = r_state;
      w_ptr_nxt    = r_ptr;
      o_scan_busy  = 1'b0;
      o_scan_valid = 1'b0;
      o_scan_done  = 1'b0;
      o_scan_idx   = '0;
      o_scan_data  = '0;
      unique case (r_state)
         S_IDLE: begin
            if (i_scan_start) begin
               w_state_nxt = S_SCAN;
               w_ptr_nxt   = HI_I;
            end
         end
         S_SCAN: begin
            o_scan_busy  = 1'b1;
            o_scan_valid = 1'b1;
            o_scan_idx   = r_ptr;
            o_scan_data  = w_scan_val;
            if (r_ptr == LO_I) begin
               w_state_nxt = S_DONE;
            end else begin
               w_ptr_nxt = r_ptr - 1'b1;
            end
         end
         S_DONE: begin
            o_scan_done = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_array_rval_scan_reader.sv
// Bench for array_rval_scan_reader: directed vector table, scan/reset
// sequences, and randomized traffic against a queue-based model.
module tb_array_rval_scan_reader;

   logic       clk;
   logic       reset;
   logic       wr_en;
   logic [3:0] wr_idx;
   logic [1:0] wr_data;
   logic       frc_en;
   logic       frc_rel;
   logic [3:0] frc_idx;
   logic [1:0] frc_data;
   logic       rd_req;
   logic [3:0] rd_idx;
   logic       rd_ack;
   logic [1:0] rd_data;
   logic       rd_oob;
   logic       rd_undef;
   logic       scan_start;
   logic       scan_busy;
   logic       scan_valid;
   logic [3:0] scan_idx;
   logic [1:0] scan_data;
   logic       scan_done;
   logic [7:0] err_count;

   int n_chk;
   int n_err;

   array_rval_scan_reader dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_wr_en      (wr_en),
      .i_wr_idx     (wr_idx),
      .i_wr_data    (wr_data),
      .i_frc_en     (frc_en),
      .i_frc_rel    (frc_rel),
      .i_frc_idx    (frc_idx),
      .i_frc_data   (frc_data),
      .i_rd_req     (rd_req),
      .i_rd_idx     (rd_idx),
      .o_rd_ack     (rd_ack),
      .o_rd_data    (rd_data),
      .o_rd_oob     (rd_oob),
      .o_rd_undef   (rd_undef),
      .i_scan_start (scan_start),
      .o_scan_busy  (scan_busy),
      .o_scan_valid (scan_valid),
      .o_scan_idx   (scan_idx),
      .o_scan_data  (scan_data),
      .o_scan_done  (scan_done),
      .o_err_count  (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       we;
      logic [3:0] wi;
      logic [1:0] wd;
      logic       fe;
      logic       fr;
      logic [3:0] fi;
      logic [1:0] fd;
      logic       rr;
      logic [3:0] ri;
      logic       e_ack;
      logic [1:0] e_data;
      logic       e_oob;
      int         e_err;
   } vec_t;

   vec_t tv[$];

   // reference model state, indexed by raw index value
   logic [1:0] m_base[4];
   logic [1:0] m_fval[4];
   bit         m_flag[4];
   int         m_err;
   int         m_q[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      wr_en = 0; wr_idx = 0; wr_data = 0;
      frc_en = 0; frc_rel = 0; frc_idx = 0; frc_data = 0;
      rd_req = 0; rd_idx = 0; scan_start = 0;
   endtask

   function automatic vec_t mk(
      logic we, logic [3:0] wi, logic [1:0] wd,
      logic fe, logic fr, logic [3:0] fi, logic [1:0] fd,
      logic rr, logic [3:0] ri,
      logic ea, logic [1:0] ed, logic eo, int ee);
      vec_t v;
      v.we = we; v.wi = wi; v.wd = wd;
      v.fe = fe; v.fr = fr; v.fi = fi; v.fd = fd;
      v.rr = rr; v.ri = ri;
      v.e_ack = ea; v.e_data = ed; v.e_oob = eo; v.e_err = ee;
      return v;
   endfunction

   // 0 legal, 1 out of range, 2 undefined
   function automatic int cls(logic [3:0] idx);
      if ($isunknown(idx)) return 2;
      if (idx < 4'd1 || idx > 4'd2) return 1;
      return 0;
   endfunction

   function automatic logic [1:0] eff(int i);
      return m_flag[i] ? m_fval[i] : m_base[i];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_base[i] = 0; m_fval[i] = 0; m_flag[i] = 0;
      end
      m_err = 0;
      m_q.delete();
   endtask

   task automatic do_reset();
      idle_in();
      reset = 1;
      cycle();
      reset = 0;
   endtask

   task automatic chk_scan_idle(input string nm);
      chk({nm, "_flags"}, 32'({scan_busy, scan_valid, scan_done}), 0);
   endtask

   initial begin
      int c;
      logic [1:0] exp_d;
      n_chk = 0;
      n_err = 0;
      idle_in();
      do_reset();

      // reset state
      chk("rst_ack", 32'(rd_ack), 0);
      chk("rst_rd", 32'({rd_data, rd_oob, rd_undef}), 0);
      chk("rst_err", 32'(err_count), 0);
      chk("rst_scan", 32'({scan_busy, scan_valid, scan_done,
                           scan_idx, scan_data}), 0);

      // directed vectors: one cycle each, checks after the edge
      tv.push_back(mk(0,0,0, 0,0,0,0, 1,1, 1,0,0,0));
      tv.push_back(mk(0,0,0, 0,0,0,0, 1,2, 1,0,0,0));
      tv.push_back(mk(0,0,0, 1,0,0,1, 0,0, 0,0,0,1));
      tv.push_back(mk(0,0,0, 0,0,0,0, 1,1, 1,0,0,1));
      tv.push_back(mk(0,0,0, 0,0,0,0, 1,2, 1,0,0,1));
      tv.push_back(mk(0,0,0, 0,0,0,0, 1,0, 1,0,1,2));
      tv.push_back(mk(0,0,0, 1,0,1,1, 1,1, 1,0,0,2));
      tv.push_back(mk(0,0,0, 0,0,0,0, 1,1, 1,1,0,2));
      tv.push_back(mk(1,1,3, 0,0,0,0, 1,1, 1,1,0,2));
      tv.push_back(mk(0,0,0, 0,0,0,0, 1,1, 1,1,0,2));
      tv.push_back(mk(0,0,0, 0,1,1,0, 1,1, 1,1,0,2));
      tv.push_back(mk(0,0,0, 0,0,0,0, 1,1, 1,3,0,2));
      tv.push_back(mk(0,0,0, 0,0,0,0, 1,3, 1,0,1,3));
      tv.push_back(mk(1,2,2, 1,1,2,1, 1,2, 1,0,0,3));
      tv.push_back(mk(0,0,0, 0,0,0,0, 1,2, 1,1,0,3));
      tv.push_back(mk(0,0,0, 0,1,2,0, 1,2, 1,1,0,3));
      tv.push_back(mk(0,0,0, 0,0,0,0, 1,2, 1,2,0,3));
      tv.push_back(mk(1,0,1, 1,0,3,0, 1,3, 1,0,1,4));
      tv.push_back(mk(1,1,1, 0,0,0,0, 1,1, 1,3,0,4));
      tv.push_back(mk(0,0,0, 0,0,0,0, 1,1, 1,1,0,4));
      tv.push_back(mk(0,0,0, 0,1,0,0, 0,0, 0,0,0,5));
      tv.push_back(mk(0,0,0, 0,0,0,0, 1,1, 1,1,0,5));

      foreach (tv[k]) begin
         wr_en = tv[k].we; wr_idx = tv[k].wi; wr_data = tv[k].wd;
         frc_en = tv[k].fe; frc_rel = tv[k].fr;
         frc_idx = tv[k].fi; frc_data = tv[k].fd;
         rd_req = tv[k].rr; rd_idx = tv[k].ri;
         cycle();
         chk($sformatf("vec%0d_ack", k), 32'(rd_ack), 32'(tv[k].e_ack));
         if (tv[k].e_ack) begin
            chk($sformatf("vec%0d_rd", k),
                32'({rd_data, rd_oob, rd_undef}),
                32'({tv[k].e_data, tv[k].e_oob, 1'b0}));
         end
         chk($sformatf("vec%0d_err", k), 32'(err_count), 32'(tv[k].e_err));
      end
      idle_in();

      // undefined index; entries now hold eff(1)=1, eff(2)=2
      rd_req = 1;
      rd_idx = 4'bxxxx;
      c = cls(rd_idx);
      exp_d = (c == 0) ? 2'(rd_idx) : 2'd0;
      cycle();
      chk("undef_rd", 32'({rd_ack, rd_data, rd_oob, rd_undef}),
          32'({1'b1, exp_d, c == 1, c == 2}));
      chk("undef_err", 32'(err_count), (c == 0) ? 32'd5 : 32'd6);

      // saturation with a long run of illegal reads
      rd_idx = 4'd3;
      for (int i = 0; i < 300; i++) cycle();
      chk("sat_err", 32'(err_count), 255);
      chk("sat_rd", 32'({rd_ack, rd_data, rd_oob, rd_undef}),
          32'({1'b1, 2'd0, 1'b1, 1'b0}));
      idle_in();
      cycle();
      chk("sat_hold", 32'(err_count), 255);

      do_reset();
      chk("rst2_err", 32'(err_count), 0);

      // scan of {2:2, 1:1}; start held through busy and done
      wr_en = 1; wr_idx = 2; wr_data = 2;
      cycle();
      wr_idx = 1; wr_data = 1;
      cycle();
      idle_in();
      scan_start = 1;
      cycle();
      chk("scan0", 32'({scan_busy, scan_valid, scan_done,
                        scan_idx, scan_data}),
          32'({3'b110, 4'd2, 2'd2}));
      cycle();
      chk("scan1", 32'({scan_busy, scan_valid, scan_done,
                        scan_idx, scan_data}),
          32'({3'b110, 4'd1, 2'd1}));
      cycle();
      chk("scan_done", 32'({scan_busy, scan_valid, scan_done}), 1);
      cycle();
      chk_scan_idle("scan_ign");
      scan_start = 0;
      cycle();
      chk_scan_idle("scan_idle");

      // reset in the middle of a scan
      scan_start = 1;
      cycle();
      scan_start = 0;
      chk("mid_busy", 32'(scan_busy), 1);
      reset = 1;
      cycle();
      reset = 0;
      chk("mid_rst", 32'({scan_busy, scan_valid, scan_done,
                          scan_idx, scan_data}), 0);
      rd_req = 1; rd_idx = 1;
      cycle();
      chk("mid_rd1", 32'({rd_ack, rd_data, rd_oob}), 32'({1'b1, 3'd0}));
      rd_idx = 2; scan_start = 1;
      cycle();
      chk("mid_rd2", 32'({rd_ack, rd_data, rd_oob}), 32'({1'b1, 3'd0}));
      idle_in();
      chk("mid_s0", 32'({scan_valid, scan_idx, scan_data}),
          32'({1'b1, 4'd2, 2'd0}));
      cycle();
      chk("mid_s1", 32'({scan_valid, scan_idx, scan_data}),
          32'({1'b1, 4'd1, 2'd0}));
      cycle();
      chk("mid_done", 32'({scan_busy, scan_valid, scan_done}), 1);
      cycle();
      chk_scan_idle("mid_end");

      // randomized traffic against the model
      do_reset();
      model_reset();
      for (int n = 0; n < 800; n++) begin
         int ev;
         int rc;
         logic [1:0] rexp;
         wr_en = ($urandom_range(99, 0) < 50);
         wr_idx = 4'($urandom_range(3, 0));
         wr_data = 2'($urandom_range(3, 0));
         frc_en = ($urandom_range(99, 0) < 20);
         frc_rel = ($urandom_range(99, 0) < 20);
         frc_idx = 4'($urandom_range(3, 0));
         frc_data = 2'($urandom_range(3, 0));
         rd_req = ($urandom_range(99, 0) < 60);
         rd_idx = 4'($urandom_range(3, 0));
         scan_start = ($urandom_range(99, 0) < 15);

         rc = cls(rd_idx);
         rexp = (rc == 0) ? eff(int'(rd_idx)) : 2'd0;
         ev = 0;
         if (wr_en && cls(wr_idx) != 0) ev = 1;
         if ((frc_en || frc_rel) && cls(frc_idx) != 0) ev = 1;
         if (rd_req && rc != 0) ev = 1;
         if (ev == 1 && m_err < 255) m_err++;
         if (wr_en && cls(wr_idx) == 0) m_base[int'(wr_idx)] = wr_data;
         if (cls(frc_idx) == 0) begin
            if (frc_en) begin
               m_flag[int'(frc_idx)] = 1;
               m_fval[int'(frc_idx)] = frc_data;
            end else if (frc_rel) begin
               m_flag[int'(frc_idx)] = 0;
            end
         end
         if (m_q.size() == 0) begin
            if (scan_start) m_q = '{2, 1, -1};
         end else begin
            void'(m_q.pop_front());
         end

         cycle();
         chk("rnd_ack", 32'(rd_ack), 32'(rd_req));
         if (rd_req) begin
            chk("rnd_rd", 32'({rd_data, rd_oob, rd_undef}),
                32'({rexp, rc == 1, rc == 2}));
         end
         chk("rnd_err", 32'(err_count), 32'(m_err));
         if (m_q.size() == 0) begin
            chk_scan_idle("rnd_idle");
         end else if (m_q[0] < 0) begin
            chk("rnd_done", 32'({scan_busy, scan_valid, scan_done}), 1);
         end else begin
            chk("rnd_scan", 32'({scan_busy, scan_valid, scan_done,
                                 scan_idx, scan_data}),
                32'({3'b110, 4'(m_q[0]), eff(m_q[0])}));
         end
      end
      idle_in();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
